// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (sign-magnitude around the same core).
module seq_divider #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] x,
  input  logic [VW-1:0] y,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          dbz
);

  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          accept;
  logic          last_iter;
  logic [CW-1:0] cnt;
  logic [DW-1:0] xs;
  logic [VW-1:0] ys;
  logic [VW-1:0] pr;
  logic [DW-1:0] quo;
  logic [VW:0]   pr_sh;
  logic          ge;
  logic [VW-1:0] pr_nx;
  logic [DW-1:0] quo_nx;
  logic [DW-1:0] x_mag;
  logic [VW-1:0] y_mag;
  logic [DW-1:0] q_fix;
  logic [VW-1:0] r_fix;

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Most-negative operands map to 2^(W-1), which still fits the unsigned core.
  assign x_mag = x[DW-1] ? DW'(-x) : x;
  assign y_mag = y[VW-1] ? VW'(-y) : y;
  assign q_fix = neg_q ? DW'(-quo_nx) : quo_nx;
  assign r_fix = neg_r ? VW'(-pr_nx) : pr_nx;
`else
  assign x_mag = x;
  assign y_mag = y;
  assign q_fix = quo_nx;
  assign r_fix = pr_nx;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic and one restoring step
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_iter  = 1'b0;
    pr_sh      = {pr, xs[DW-1]};
    ge         = (pr_sh >= {1'b0, ys});
    pr_nx      = VW'(ge ? (pr_sh - {1'b0, ys}) : pr_sh);
    quo_nx     = {quo[DW-2:0], ge};
    case (state)
      IDLE: begin
        if (start && ready) begin
          accept     = 1'b1;
          next_state = (y == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == CW'(DW - 1)) begin
          last_iter  = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs; ready stays low for the cycle done is shown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b1;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
      cnt   <= '0;
      xs    <= '0;
      ys    <= '0;
      pr    <= '0;
      quo   <= '0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      ready <= (next_state == IDLE) && (state != DONE);
      done  <= (state == DONE);
      if (accept) begin
        xs  <= x_mag;
        ys  <= y_mag;
        pr  <= '0;
        quo <= '0;
        cnt <= '0;
`ifdef SEQ_DIV_SIGNED_EN
        neg_q <= x[DW-1] ^ y[VW-1];
        neg_r <= x[DW-1];
`endif
        if (y == '0) begin
          q   <= '1;
          r   <= '0;
          dbz <= 1'b1;
        end
      end else if (state == CALC) begin
        pr  <= pr_nx;
        quo <= quo_nx;
        xs  <= {xs[DW-2:0], 1'b0};
        cnt <= cnt + CW'(1);
        if (last_iter) begin
          q   <= q_fix;
          r   <= r_fix;
          dbz <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (default DW=8, VW=4).
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x_i = '0;
  logic [3:0] y_i = '0;
  logic       ready;
  logic       done;
  logic [7:0] q;
  logic [3:0] r;
  logic       dbz;

  int total = 0;
  int bad   = 0;

  seq_divider #(.DW(8), .VW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x_i),
    .y     (y_i),
    .ready (ready),
    .done  (done),
    .q     (q),
    .r     (r),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [3:0] y;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) chk({name, "_ready_timeout"}, 32'(ready), 32'd1);
  endtask

  // Issue one division, then wait (bounded) for done; lat counts edges after the accept edge.
  task automatic issue(input logic [7:0] xv, input logic [3:0] yv, output int lat);
    x_i   = xv;
    y_i   = yv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x_i   = ~xv;
    y_i   = ~yv;
    lat   = 0;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    wait_ready(name);
    issue(v.x, v.y, lat);
    chk({name, "_lat"}, 32'(lat), 32'(v.lat));
    chk({name, "_q"}, 32'(q), 32'(v.q));
    chk({name, "_r"}, 32'(r), 32'(v.r));
    chk({name, "_dbz"}, 32'(dbz), 32'(v.dbz));
    chk({name, "_ready_at_done"}, 32'(ready), 32'd0);
    @(posedge clk); #1;
    chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({name, "_ready_after"}, 32'(ready), 32'd1);
    chk({name, "_q_hold"}, 32'(q), 32'(v.q));
  endtask

  function automatic vec_t mk(input int xv, input int yv, input int qv, input int rv,
                              input int dv, input int lv);
    vec_t v;
    v.x = 8'(xv); v.y = 4'(yv); v.q = 8'(qv); v.r = 4'(rv); v.dbz = 1'(dv); v.lat = lv;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dones;
    int ok;

    // Reset state
    #12;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef SEQ_DIV_SIGNED_EN
    vecs.push_back(mk(8'h9C, 7, 8'hF2, 4'hE, 0, 9));
    vecs.push_back(mk(8'h80, 4'hF, 8'h80, 0, 0, 9));
    vecs.push_back(mk(7, 4'hE, 8'hFD, 1, 0, 9));
    vecs.push_back(mk(8'hF9, 2, 8'hFD, 4'hF, 0, 9));
    vecs.push_back(mk(100, 4'h8, 8'hF4, 4, 0, 9));
    vecs.push_back(mk(123, 0, 255, 0, 1, 1));
    vecs.push_back(mk(9, 3, 3, 0, 0, 9));
`else
    vecs.push_back(mk(200, 7, 28, 4, 0, 9));
    vecs.push_back(mk(123, 0, 255, 0, 1, 1));
    vecs.push_back(mk(9, 3, 3, 0, 0, 9));
    vecs.push_back(mk(5, 15, 0, 5, 0, 9));
    vecs.push_back(mk(255, 1, 255, 0, 0, 9));
    vecs.push_back(mk(0, 9, 0, 0, 0, 9));
    vecs.push_back(mk(255, 15, 17, 0, 0, 9));
    vecs.push_back(mk(100, 3, 33, 1, 0, 9));
`endif
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start held high with operands churning: only the accepted pair counts
    wait_ready("hs");
    x_i   = 8'd60;
    y_i   = 4'd7;
    start = 1'b1;
    @(posedge clk); #1;
    lat   = 0;
    dones = 0;
    while (!done && lat < 30) begin
      x_i = 8'($urandom);
      y_i = 4'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    if (done) dones++;
    start = 1'b0;
    chk("hs_lat", 32'(lat), 32'd9);
    chk("hs_q", 32'(q), 32'd8);
    chk("hs_r", 32'(r), 32'd4);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("hs_one_done", 32'(dones), 32'd1);
    chk("hs_q_hold", 32'(q), 32'd8);
    chk("hs_r_hold", 32'(r), 32'd4);

    // Reset in the middle of a calculation
    wait_ready("rst_mid");
    x_i   = 8'd200;
    y_i   = 4'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_q", 32'(q), 32'd0);
    chk("midrst_r", 32'(r), 32'd0);
    chk("midrst_dbz", 32'(dbz), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    run_vec(mk(17, 5, 3, 2, 0, 9), "after_rst");

`ifndef SEQ_DIV_SIGNED_EN
    // Exhaustive sweep against the division identity
    for (int xv = 0; xv < 256; xv++) begin
      for (int yv = 0; yv < 16; yv++) begin
        wait_ready("sweep");
        issue(8'(xv), 4'(yv), lat);
        if (yv == 0)
          ok = int'(done && q == 8'hFF && r == 4'h0 && dbz);
        else
          ok = int'(done && !dbz && (xv == int'(q) * yv + int'(r)) && (int'(r) < yv));
        total++;
        if (ok != 1) begin
          bad++;
          $display("FAIL sweep x=%0d y=%0d: got q=%0d r=%0d dbz=%0d done=%0d", xv, yv, q, r, dbz, done);
        end
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
